// File: rtl/seg_pkg.sv
// Shared types and code constants for the 7-segment scan path.
package seg_pkg;

    // 5-bit digit code: bit 4 selects glyph set (1) or hex value (0).
    typedef logic [4:0] digit_code_t;

    // Glyph-set codes understood by the downstream segment decoder.
    typedef enum logic [4:0] {
        CODE_BLANK = 5'h10,
        CODE_DASH  = 5'h11,
        CODE_L     = 5'h12,
        CODE_O     = 5'h13,
        CODE_A     = 5'h14,
        CODE_D     = 5'h15,
        CODE_J     = 5'h16,
        CODE_U     = 5'h17,
        CODE_M     = 5'h18,
        CODE_P     = 5'h19,
        CODE_S     = 5'h1A,
        CODE_V     = 5'h1B,
        CODE_E     = 5'h1C
    } glyph_e;

    // One display-buffer entry.
    typedef struct packed {
        logic        blink;
        digit_code_t code;
    } entry_t;

    localparam entry_t BLANK_ENTRY = '{blink: 1'b0, code: CODE_BLANK};

endpackage

// File: rtl/seg_prescaler.sv
// Digit-slot counter: counts 0..PRESCALE-1 and flags the slot wrap and
// whether the cycle after the coming edge falls in the blanking window.
module seg_prescaler #(
    parameter int unsigned PRESCALE     = 50000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    output logic wrap,
    output logic blank_next
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST      = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // Next count and the strobes derived from it.
    always_comb begin
        wrap       = (cnt == LAST);
        cnt_next   = wrap ? '0 : cnt + CW'(1);
        blank_next = (cnt_next < BLANK_LIM);
    end

    // Slot counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt_next;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with inter-digit blanking
// and per-digit blink. Outputs are registered from next-state values so
// they line up with the scan position without a cycle of lag.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned AW           = 2,
    parameter int unsigned PRESCALE     = 50000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [4:0]            wr_data,
    input  logic                  wr_blink,
    input  logic                  clear,
    output logic [4:0]            digit_code,
    output logic [NUM_DIGITS-1:0] digit_en,
    output logic                  frame_tick
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_DIGITS - 1);
    localparam int unsigned   FW       = $clog2(BLINK_FRAMES + 1);
    localparam logic [FW-1:0] FLAST    = FW'(BLINK_FRAMES - 1);

    entry_t        buffer [NUM_DIGITS];
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_next;
    logic [FW-1:0] frames;
    logic          blink_phase;
    logic          phase_next;
    logic          frame_start;
    logic          wr_ok;
    logic          wrap;
    logic          blank_next;
    entry_t        shown;

    seg_prescaler #(
        .PRESCALE    (PRESCALE),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_prescaler (
        .clk       (clk),
        .rst_n     (rst_n),
        .wrap      (wrap),
        .blank_next(blank_next)
    );

    // Next scan position, blink phase and the entry to be displayed;
    // the entry bypasses this cycle's clear/write so updates show at once.
    always_comb begin
        wr_ok       = wr_en && (int'(wr_addr) < int'(NUM_DIGITS));
        frame_start = wrap && (idx == LAST_IDX);
        idx_next    = idx;
        if (wrap) idx_next = (idx == LAST_IDX) ? '0 : idx + AW'(1);
        phase_next  = blink_phase ^ (frame_start && (frames == FLAST));
        shown       = buffer[idx_next];
        if (clear)
            shown = BLANK_ENTRY;
        else if (wr_ok && (wr_addr == idx_next))
            shown = '{blink: wr_blink, code: wr_data};
    end

    // Display buffer: clear beats write, out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) buffer[i] <= BLANK_ENTRY;
        end else if (wr_ok) begin
            buffer[wr_addr] <= '{blink: wr_blink, code: wr_data};
        end
    end

    // Digit index, frame counter and blink phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx         <= '0;
            frames      <= '0;
            blink_phase <= 1'b1;
        end else begin
            idx         <= idx_next;
            blink_phase <= phase_next;
            if (frame_start) frames <= (frames == FLAST) ? '0 : frames + FW'(1);
        end
    end

    // Registered outputs to the segment decoder.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            digit_code <= CODE_BLANK;
            digit_en   <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_start;
            if (blank_next || (shown.blink && !phase_next)) begin
                digit_code <= CODE_BLANK;
                digit_en   <= '0;
            end else begin
                digit_code <= shown.code;
                digit_en   <= NUM_DIGITS'(1) << idx_next;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: the driver applies stimulus on the
// falling edge and queues the expected outputs of the following cycle from
// a time-based reference model; the monitor compares after each rising edge.
module tb_seg_scan_ctrl;

    localparam int N  = 4;
    localparam int P  = 8;
    localparam int BL = 2;
    localparam int BF = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [4:0] wr_data = '0;
    logic       wr_blink = 1'b0;
    logic       clear = 1'b0;
    logic [4:0] digit_code;
    logic [3:0] digit_en;
    logic       frame_tick;

    seg_scan_ctrl #(
        .NUM_DIGITS  (N),
        .AW          (2),
        .PRESCALE    (P),
        .BLANK_CYCLES(BL),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_blink  (wr_blink),
        .clear     (clear),
        .digit_code(digit_code),
        .digit_en  (digit_en),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] en;
        logic [4:0] code;
        logic       tick;
        int         t;
    } exp_t;

    exp_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    int         t = 0;
    logic [4:0] m_code [N];
    logic       m_blink[N];

    // Reference: scan position is a pure function of cycles since reset.
    function automatic exp_t predict(input int tt);
        exp_t e;
        int   cnt, id, frame;
        bit   visible;
        cnt     = tt % P;
        id      = (tt / P) % N;
        frame   = tt / (P * N);
        visible = ((frame / BF) % 2) == 0;
        e.t     = tt;
        e.tick  = (tt > 0) && (tt % (P * N) == 0);
        if (cnt < BL || (m_blink[id] && !visible)) begin
            e.en   = 4'b0000;
            e.code = 5'h10;
        end else begin
            e.en   = 4'b0001 << id;
            e.code = m_code[id];
        end
        return e;
    endfunction

    task automatic step(input logic r, input logic we, input int a,
                        input logic [4:0] d, input logic b, input logic c);
        @(negedge clk);
        rst_n    = r;
        wr_en    = we;
        wr_addr  = a[1:0];
        wr_data  = d;
        wr_blink = b;
        clear    = c;
        if (!r || c) begin
            for (int i = 0; i < N; i++) begin
                m_code[i]  = 5'h10;
                m_blink[i] = 1'b0;
            end
        end else if (we && a < N) begin
            m_code[a]  = d;
            m_blink[a] = b;
        end
        t = r ? t + 1 : 0;
        sb.push_back(predict(t));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 5'h00, 1'b0, 1'b0);
    endtask

    // Monitor: one expected entry per cycle once stimulus is running.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (digit_en !== e.en) begin
                    errors++;
                    $display("FAIL digit_en t=%0d got=%b want=%b", e.t, digit_en, e.en);
                end
                checks++;
                if (digit_code !== e.code) begin
                    errors++;
                    $display("FAIL digit_code t=%0d got=%h want=%h", e.t, digit_code, e.code);
                end
                checks++;
                if (frame_tick !== e.tick) begin
                    errors++;
                    $display("FAIL frame_tick t=%0d got=%b want=%b", e.t, frame_tick, e.tick);
                end
            end
        end
    end

    initial begin
        // reset, then hex 3 into digit 2 during cycle 0
        step(1'b0, 1'b0, 0, 5'h00, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2, 5'h03, 1'b0, 1'b0);
        while (t < 4) idle(1);
        // write to the digit on display during cycle 4
        step(1'b1, 1'b1, 0, 5'h09, 1'b0, 1'b0);
        // blinking E on digit 1, then run through several blink periods
        step(1'b1, 1'b1, 1, 5'h1C, 1'b1, 1'b0);
        while (t < 200) idle(1);

        // load every digit, then clear with a colliding write
        step(1'b1, 1'b1, 0, 5'h0A, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1, 5'h0B, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2, 5'h0C, 1'b1, 1'b0);
        step(1'b1, 1'b1, 3, 5'h13, 1'b0, 1'b0);
        idle(40);
        step(1'b1, 1'b1, 0, 5'h07, 1'b0, 1'b1);
        idle(40);

        // reset in the middle of digit 1's slot
        step(1'b0, 1'b0, 0, 5'h00, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1, 5'h05, 1'b0, 1'b0);
        while (t < 13) idle(1);
        step(1'b0, 1'b1, 3, 5'h0F, 1'b0, 1'b0);
        idle(80);

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 499) != 0,
                 ($urandom % 4) == 0,
                 int'($urandom_range(0, N - 1)),
                 5'($urandom),
                 1'($urandom),
                 $urandom_range(0, 149) == 0);
        end
        idle(2);
        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a multi-digit 7-segment display; sits directly upstream of the per-digit 5-bit-code segment decoder.
- Holds a display buffer of 5-bit digit codes. Bit 4 = 0 selects hex 0-F; bit 4 = 1 selects glyph set (0 = blank, 1 = '-', 2 = L, ... 12 = E).
- Each slot it presents one digit's code to the decoder and drives the matching one-hot digit enable.
- Adds inter-digit blanking (anti-ghosting) and per-digit blink.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; buffer depth.
- AW, 2: address width; must equal clog2(NUM_DIGITS).
- PRESCALE, 50000: clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 16: cycles at the start of each slot with all digits dark; 0 <= BLANK_CYCLES < PRESCALE.
- BLINK_FRAMES, 64: full scan frames per blink half-period; must be >= 1.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- wr_en  in  1  write one buffer entry this cycle.
- wr_addr  in  AW  digit index to write; values >= NUM_DIGITS are ignored.
- wr_data  in  5  digit code to store.
- wr_blink  in  1  blink flag stored with the entry.
- clear  in  1  sync clear of the whole buffer.
- digit_code  out  5  code to the segment decoder input.
- digit_en  out  NUM_DIGITS  one-hot active-high digit enable; all zeros = dark.
- frame_tick  out  1  one-cycle pulse at the start of every frame after the first.

Behaviour:
- Reset (rst_n = 0 at an edge):
  - Every buffer entry becomes code 5'b1_0000 (blank) with blink = 0.
  - Slot counter cnt = 0, digit index idx = 0, frame counter = 0, blink_phase = 1 (visible).
  - digit_code = 5'b1_0000, digit_en = 0, frame_tick = 0.
  - Reset applied mid-slot or mid-write takes effect at that edge; the write is lost.
- Slot counter: cnt counts 0 .. PRESCALE-1. On wrap, idx increments; idx wraps NUM_DIGITS-1 -> 0.
- Frame start:
  - Occurs when idx wraps to 0 and cnt = 0.
  - frame_tick is high for exactly that cycle. It is not asserted in the first cycle after reset.
  - The frame counter increments at each frame start. When it reaches BLINK_FRAMES it resets to 0 and blink_phase toggles.
- Outputs are registered and computed from the next-state idx/cnt, so they are aligned with idx/cnt with no lag:
  - cnt < BLANK_CYCLES: digit_en = 0, digit_code = 5'b1_0000.
  - Otherwise, if the entry blink = 1 and blink_phase = 0: digit_en = 0, digit_code = 5'b1_0000.
  - Otherwise: digit_en = one-hot(idx), digit_code = buffer[idx].code.
- Writes:
  - Take effect at the clock edge.
  - A write to the digit currently displayed shows on digit_code in the next cycle.
- clear and wr_en in the same cycle: clear wins and the write is dropped.
- Out-of-range wr_addr: no state change.
- Scan counters and blink state are unaffected by writes and by clear.
- digit_en is never more than one-hot. A digit is never enabled during its blanking window.

Decomposition:
- Shared package (seg_pkg):
  - Code constant CODE_BLANK = 5'b1_0000 and glyph constants (DASH, L, O, A, D, J, U, M, P, S, V, E as 5'b1_xxxx).
  - Digit-code typedef (5 bits: mode bit + 4-bit value).
- One natural sub-module, seg_prescaler: slot counter producing cnt, the slot-wrap strobe and the blank-window flag.
- Buffer, idx, frame/blink logic and the output registers stay in the top module.

Test Plan (bench parameters: NUM_DIGITS = 4, PRESCALE = 8, BLANK_CYCLES = 2, BLINK_FRAMES = 2):
- Reset release, no writes -> cycles 0-1 digit_en = 0. Cycles 2-7 digit_en = 4'b0001, code = 5'h10. Cycle 8 idx = 1. frame_tick high only at cycles 32, 64, ...
- Write wr_addr = 2, wr_data = 5'h03 at cycle 0 -> cycles 18-23 digit_en = 4'b0100, code = 5'h03. Other slots show 5'h10.
- Write wr_addr = 1, wr_data = 5'h1C (E), wr_blink = 1 -> digit 1 lit (cycles 10-15 each frame) in frames 0-1. Dark (digit_en = 0, code = 5'h10) in frames 2-3 (cycles 64-127). Lit again in frames 4-5.
- clear and wr_en (addr 0, data 5'h07) in the same cycle after buffer loaded -> all digits show 5'h10 next frame; scan timing unchanged.
- rst_n low for one edge at cycle 13 (idx = 1, cnt = 5) -> next cycle digit_en = 0, code = 5'h10. Scan restarts from idx = 0, cnt = 0. No frame_tick at the restart.
- Write to displayed digit (addr 0, data 5'h09, at cycle 4) -> digit_code = 5'h09 at cycle 5, digit_en stays 4'b0001.
